// File: rtl/ekf_stage_pkg.sv
// rtl/ekf_stage_pkg.sv - stage codes, Q-format constants and FSM encoding for the EKF stage sequencer
package ekf_stage_pkg;

  // Stage command codes shared by stage_val and stage_rdy
  localparam logic [2:0] STG_IDLE  = 3'b000;
  localparam logic [2:0] STG_PRD   = 3'b001;
  localparam logic [2:0] STG_NEW   = 3'b010;
  localparam logic [2:0] STG_UPD   = 3'b011;
  localparam logic [2:0] STG_ASSOC = 3'b100;

  // Signed fixed-point layout of data words (Q1.12.19) and angles
  localparam int DATA_INT_BIT  = 12;
  localparam int DATA_DEC_BIT  = 19;
  localparam int ANGLE_DEC_BIT = 15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECIDE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - loadable cycle counter with clear, enable and expired flag
module stage_watchdog #(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  logic [CW-1:0] cnt;

  // Clear wins over load, load wins over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt + 1'b1;
  end

  // Expired is level-true while the count sits on the limit
  always_comb begin
    expired = (cnt == limit);
  end

endmodule

// File: rtl/ekf_stage_sequencer.sv
// rtl/ekf_stage_sequencer.sv - EKF core stage initiator (PRD -> NEW|UPD); ASSOC_STAGE_EN inserts ASSOC before UPD
module ekf_stage_sequencer
  import ekf_stage_pkg::*;
#(
  parameter int RSA_DW      = 1 + DATA_INT_BIT + DATA_DEC_BIT,
  parameter int RSA_AW      = 2 + ANGLE_DEC_BIT,
  parameter int ROW_LEN     = 10,
  parameter int MAX_LM      = 64,
  parameter int VAL_HOLD    = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               frame_val,
  output logic               frame_rdy,
  input  logic [RSA_DW-1:0]  vlr_in,
  input  logic [RSA_AW-1:0]  alpha_in,
  input  logic               obs_val,
  input  logic               obs_new,
  input  logic [ROW_LEN-1:0] obs_idx,
  input  logic [RSA_DW-1:0]  rk_in,
  input  logic [RSA_AW-1:0]  phi_in,
  output logic [2:0]         stage_val,
  input  logic [2:0]         stage_rdy,
  input  logic [RSA_DW-1:0]  S_data,
  output logic [ROW_LEN-1:0] landmark_num,
  output logic [ROW_LEN-1:0] l_k,
  output logic [RSA_DW-1:0]  vlr,
  output logic [RSA_AW-1:0]  alpha,
  output logic [RSA_DW-1:0]  rk,
  output logic [RSA_AW-1:0]  phi,
  output logic [RSA_DW-1:0]  s_capt,
  output logic               done,
  output logic               err_timeout,
  output logic               lm_full
);

  localparam int HW = $clog2(VAL_HOLD + 1);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(VAL_HOLD - 1);
  localparam logic [CW-1:0]      WD_LIMIT  = CW'(TIMEOUT_CYC - 1);
  localparam logic [ROW_LEN-1:0] LM_CAP    = ROW_LEN'(MAX_LM);

  state_t              state, state_nxt;
  logic [2:0]          cur_stage, nxt_stage;
  logic [ROW_LEN-1:0]  nxt_lk;
  logic [HW-1:0]       hold_cnt;
  logic                rdy_seen;
  logic [RSA_DW-1:0]   s_pend;
  logic                obs_val_q, obs_new_q;
  logic [ROW_LEN-1:0]  obs_idx_q;
  logic                set_full, lm_inc, capt_assoc;
  logic                accept, hit, hold_last, wd_expired, timeout, is_new;

  assign accept    = (state == S_IDLE) && frame_val;
  assign hit       = ((state == S_ISSUE) || (state == S_WAIT)) && (stage_rdy == cur_stage);
  assign hold_last = (hold_cnt == HOLD_LAST);
  assign timeout   = (state == S_WAIT) && !hit && wd_expired;
  assign is_new    = obs_new_q || (obs_idx_q >= landmark_num);

  // Wait-for-completion budget; restarts whenever the FSM is outside S_WAIT
  stage_watchdog #(.CW(CW)) u_wd (
    .clk      (clk),
    .rst_n    (sys_rst),
    .clr      (state != S_WAIT),
    .load     (1'b0),
    .load_val ('0),
    .en       (state == S_WAIT),
    .limit    (WD_LIMIT),
    .expired  (wd_expired)
  );

  // State register
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state plus the stage/index/flag decisions taken in S_DECIDE
  always_comb begin
    state_nxt  = state;
    nxt_stage  = cur_stage;
    nxt_lk     = l_k;
    set_full   = 1'b0;
    lm_inc     = 1'b0;
    capt_assoc = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_val) begin
          state_nxt = S_ISSUE;
          nxt_stage = STG_PRD;
        end
      end
      S_ISSUE: begin
        if (hold_last) state_nxt = (rdy_seen || hit) ? S_DECIDE : S_WAIT;
      end
      S_WAIT: begin
        if (hit)             state_nxt = S_DECIDE;
        else if (wd_expired) state_nxt = S_DONE;
      end
      S_DECIDE: begin
        state_nxt = S_DONE;
        case (cur_stage)
          STG_PRD: begin
            if (obs_val_q) begin
              if (is_new) begin
                if (landmark_num < LM_CAP) begin
                  nxt_stage = STG_NEW;
                  nxt_lk    = landmark_num;
                  state_nxt = S_ISSUE;
                end else begin
                  set_full = 1'b1;
                end
              end else begin
`ifdef ASSOC_STAGE_EN
                nxt_stage = STG_ASSOC;
`else
                nxt_stage = STG_UPD;
`endif
                nxt_lk    = obs_idx_q;
                state_nxt = S_ISSUE;
              end
            end
          end
`ifdef ASSOC_STAGE_EN
          STG_ASSOC: begin
            capt_assoc = 1'b1;
            nxt_stage  = STG_UPD;
            state_nxt  = S_ISSUE;
          end
`endif
          STG_NEW: lm_inc = 1'b1;
          default: ;
        endcase
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; stage_val is driven only while issuing
  always_comb begin
    frame_rdy = (state == S_IDLE);
    stage_val = (state == S_ISSUE) ? cur_stage : STG_IDLE;
    done      = (state == S_DONE);
  end

  // Hold counter and early-completion flag for the current issue window
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      hold_cnt <= '0;
      rdy_seen <= 1'b0;
      s_pend   <= '0;
    end else begin
      hold_cnt <= (state == S_ISSUE) ? hold_cnt + 1'b1 : '0;
      if (state != S_ISSUE) rdy_seen <= 1'b0;
      else if (hit)         rdy_seen <= 1'b1;
      if (hit && !rdy_seen) s_pend <= S_data;
    end
  end

  // Frame operands, stage selection, landmark count, result capture and sticky flags
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      vlr          <= '0;
      alpha        <= '0;
      rk           <= '0;
      phi          <= '0;
      obs_val_q    <= 1'b0;
      obs_new_q    <= 1'b0;
      obs_idx_q    <= '0;
      cur_stage    <= STG_IDLE;
      l_k          <= '0;
      landmark_num <= '0;
      s_capt       <= '0;
      err_timeout  <= 1'b0;
      lm_full      <= 1'b0;
    end else begin
      cur_stage <= nxt_stage;
      l_k       <= nxt_lk;
      if (accept) begin
        vlr         <= vlr_in;
        alpha       <= alpha_in;
        rk          <= rk_in;
        phi         <= phi_in;
        obs_val_q   <= obs_val;
        obs_new_q   <= obs_new;
        obs_idx_q   <= obs_idx;
        err_timeout <= 1'b0;
        lm_full     <= 1'b0;
      end
      if (timeout)    err_timeout  <= 1'b1;
      if (set_full)   lm_full      <= 1'b1;
      if (lm_inc)     landmark_num <= landmark_num + 1'b1;
      if (capt_assoc) s_capt       <= s_pend;
      if ((state == S_DONE) && !err_timeout) s_capt <= s_pend;
    end
  end

endmodule
